// File: rtl/iv_mailbox_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// iv_mailbox_pkg: register offsets and status layout for iv_mailbox
// Rev 1.0
// ------------------------------------------------------------------
package iv_mailbox_pkg;

    localparam logic OFS_DATA   = 1'b0;
    localparam logic OFS_STATUS = 1'b1;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UNF   = 5;

    typedef struct packed {
        logic rx_unf;
        logic tx_ovf;
        logic rx_full;
        logic rx_empty;
        logic tx_empty;
        logic tx_full;
    } iv_mailbox_status_t;

    // Places each flag at its architectural bit; bits 7:6 stay zero.
    function automatic logic [7:0] status_byte(input iv_mailbox_status_t s);
        logic [7:0] b;
        b              = 8'h00;
        b[ST_TX_FULL]  = s.tx_full;
        b[ST_TX_EMPTY] = s.tx_empty;
        b[ST_RX_EMPTY] = s.rx_empty;
        b[ST_RX_FULL]  = s.rx_full;
        b[ST_TX_OVF]   = s.tx_ovf;
        b[ST_RX_UNF]   = s.rx_unf;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iv_mailbox_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// iv_fifo: synchronous FIFO, push on full allowed with a same-cycle pop
// Rev 1.0
// ------------------------------------------------------------------
module iv_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign rdata_o   = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_do_push) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (w_do_pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iv_mailbox.sv
`default_nettype none
// ------------------------------------------------------------------
// iv_mailbox: multi-channel TX/RX byte mailbox on the IV bus
// Rev 1.0
// ------------------------------------------------------------------
module iv_mailbox
    import iv_mailbox_pkg::*;
#(
    parameter int         CHANNELS  = 2,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    input  logic [7:0]            cpu_addr,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_hit,
    output logic [CHANNELS-1:0]   tx_valid,
    input  logic [CHANNELS-1:0]   tx_ready,
    output logic [8*CHANNELS-1:0] tx_data,
    input  logic [CHANNELS-1:0]   rx_valid,
    output logic [CHANNELS-1:0]   rx_ready,
    input  logic [8*CHANNELS-1:0] rx_data
);

    localparam int CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [8:0]          w_ofs;
    logic                w_in_win;
    logic [CIW-1:0]      w_chan;

    logic [CHANNELS-1:0] w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0]          w_rx_head [CHANNELS];
    logic [7:0]          w_status  [CHANNELS];

    logic [CHANNELS-1:0] tx_ovf_q, tx_ovf_d;
    logic [CHANNELS-1:0] rx_unf_q, rx_unf_d;
    logic [7:0]          cpu_dout_q, cpu_dout_d;
    logic                cpu_hit_q, cpu_hit_d;

    // 9-bit difference so addresses below the base show up as negative.
    assign w_ofs    = {1'b0, cpu_addr} - {1'b0, BASE_ADDR};
    assign w_in_win = !w_ofs[8] && (w_ofs < 9'(2 * CHANNELS));
    assign w_chan   = w_ofs[CIW:1];

    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~w_rx_full;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic               w_sel_data;
        logic               w_sel_stat;
        logic               w_tx_push;
        logic               w_tx_pop;
        logic               w_rx_push;
        logic               w_rx_rd;
        logic [7:0]         w_tx_head;
        iv_mailbox_status_t w_st;

        assign w_sel_data = w_in_win && (w_ofs[8:1] == 8'(c)) && (w_ofs[0] == OFS_DATA);
        assign w_sel_stat = w_in_win && (w_ofs[8:1] == 8'(c)) && (w_ofs[0] == OFS_STATUS);

        assign w_tx_push = cpu_wr && w_sel_data;
        assign w_tx_pop  = tx_valid[c] && tx_ready[c];
        assign w_rx_push = rx_valid[c] && rx_ready[c];
        // A read collided with a write is answered with zero and never pops.
        assign w_rx_rd   = cpu_rd && !cpu_wr && w_sel_data;

        iv_fifo #(
            .WIDTH (8),
            .DEPTH (DEPTH)
        ) u_tx_fifo (
            .clk     (clk),
            .n_reset (n_reset),
            .push_i  (w_tx_push),
            .wdata_i (cpu_din),
            .pop_i   (w_tx_pop),
            .rdata_o (w_tx_head),
            .full_o  (w_tx_full[c]),
            .empty_o (w_tx_empty[c])
        );

        iv_fifo #(
            .WIDTH (8),
            .DEPTH (DEPTH)
        ) u_rx_fifo (
            .clk     (clk),
            .n_reset (n_reset),
            .push_i  (w_rx_push),
            .wdata_i (rx_data[8*c +: 8]),
            .pop_i   (w_rx_rd),
            .rdata_o (w_rx_head[c]),
            .full_o  (w_rx_full[c]),
            .empty_o (w_rx_empty[c])
        );

        assign tx_data[8*c +: 8] = w_tx_head;

        // Set terms are OR-ed after the clear so a coincident set wins.
        assign tx_ovf_d[c] = (w_tx_push && w_tx_full[c] && !w_tx_pop)
                           || (tx_ovf_q[c] && !(cpu_wr && w_sel_stat && cpu_din[ST_TX_OVF]));
        assign rx_unf_d[c] = (w_rx_rd && w_rx_empty[c])
                           || (rx_unf_q[c] && !(cpu_wr && w_sel_stat && cpu_din[ST_RX_UNF]));

        assign w_st.tx_full  = w_tx_full[c];
        assign w_st.tx_empty = w_tx_empty[c];
        assign w_st.rx_empty = w_rx_empty[c];
        assign w_st.rx_full  = w_rx_full[c];
        assign w_st.tx_ovf   = tx_ovf_q[c];
        assign w_st.rx_unf   = rx_unf_q[c];
        assign w_status[c]   = status_byte(w_st);
    end

    always_comb begin
        cpu_dout_d = 8'h00;
        cpu_hit_d  = cpu_rd && w_in_win;
        if (cpu_hit_d && !cpu_wr) begin
            if (w_ofs[0] == OFS_STATUS) begin
                cpu_dout_d = w_status[w_chan];
            end else if (!w_rx_empty[w_chan]) begin
                cpu_dout_d = w_rx_head[w_chan];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            tx_ovf_q   <= '0;
            rx_unf_q   <= '0;
            cpu_dout_q <= 8'h00;
            cpu_hit_q  <= 1'b0;
        end else begin
            tx_ovf_q   <= tx_ovf_d;
            rx_unf_q   <= rx_unf_d;
            cpu_dout_q <= cpu_dout_d;
            cpu_hit_q  <= cpu_hit_d;
        end
    end

    assign cpu_dout = cpu_dout_q;
    assign cpu_hit  = cpu_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_iv_mailbox.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_iv_mailbox: directed + random bench against a queue-based model
// Rev 1.0
// ------------------------------------------------------------------
module tb_iv_mailbox;

    localparam int         CH    = 2;
    localparam int         DEPTH = 4;
    localparam logic [7:0] BASE  = 8'hF0;

    logic            clk;
    logic            n_reset;
    logic            cpu_wr, cpu_rd;
    logic [7:0]      cpu_addr, cpu_din, cpu_dout;
    logic            cpu_hit;
    logic [CH-1:0]   tx_valid, tx_ready, rx_valid, rx_ready;
    logic [8*CH-1:0] tx_data, rx_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq [CH][$];
    logic [7:0] rxq [CH][$];
    bit         ovf [CH];
    bit         unf [CH];

    iv_mailbox #(
        .CHANNELS  (CH),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .cpu_wr   (cpu_wr),
        .cpu_rd   (cpu_rd),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_hit  (cpu_hit),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            txq[c].delete();
            rxq[c].delete();
            ovf[c] = 1'b0;
            unf[c] = 1'b0;
        end
    endtask

    // One clock: check host-side outputs, predict the edge, then check read data.
    task automatic step();
        int         off, ch, txs[CH], rxs[CH];
        bit         inwin, isstat, txp[CH];
        logic [7:0] st[CH];
        logic [7:0] edout;
        logic       ehit;
        for (int c = 0; c < CH; c++) begin
            txs[c] = txq[c].size();
            rxs[c] = rxq[c].size();
            st[c]  = {2'b00, unf[c], ovf[c], rxs[c] == DEPTH, rxs[c] == 0,
                      txs[c] == 0, txs[c] == DEPTH};
            chk("tx_valid", 16'(tx_valid[c]), 16'(txs[c] > 0));
            chk("rx_ready", 16'(rx_ready[c]), 16'(rxs[c] < DEPTH));
            if (txs[c] > 0) chk("tx_data", 16'(tx_data[8*c +: 8]), 16'(txq[c][0]));
        end
        off    = int'(cpu_addr) - int'(BASE);
        inwin  = (off >= 0) && (off < 2 * CH);
        ch     = inwin ? off / 2 : 0;
        isstat = inwin && (off % 2 == 1);
        for (int c = 0; c < CH; c++) begin
            txp[c] = (txs[c] > 0) && tx_ready[c];
            if (txp[c]) void'(txq[c].pop_front());
        end
        if (cpu_wr && inwin) begin
            if (isstat) begin
                if (cpu_din[4]) ovf[ch] = 1'b0;
                if (cpu_din[5]) unf[ch] = 1'b0;
            end else if (txs[ch] < DEPTH || txp[ch]) begin
                txq[ch].push_back(cpu_din);
            end else begin
                ovf[ch] = 1'b1;
            end
        end
        ehit  = cpu_rd && inwin;
        edout = 8'h00;
        if (ehit && !cpu_wr) begin
            if (isstat) edout = st[ch];
            else if (rxs[ch] > 0) edout = rxq[ch].pop_front();
            else unf[ch] = 1'b1;
        end
        for (int c = 0; c < CH; c++) begin
            if (rx_valid[c] && rxs[c] < DEPTH) rxq[c].push_back(rx_data[8*c +: 8]);
        end
        @(posedge clk);
        #1;
        chk("cpu_hit", 16'(cpu_hit), 16'(ehit));
        chk("cpu_dout", 16'(cpu_dout), 16'(edout));
    endtask

    task automatic idle();
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cpu_wr   = 1'b1;
        cpu_rd   = 1'b0;
        cpu_addr = a;
        cpu_din  = d;
        step();
        cpu_wr   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = a;
        step();
        cpu_rd   = 1'b0;
    endtask

    task automatic do_reset();
        n_reset  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_rd   = 1'b0;
        tx_ready = '0;
        rx_valid = '0;
        @(posedge clk);
        #1;
        n_reset  = 1'b1;
        model_clear();
        chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
        chk("rst_rx_ready", 16'(rx_ready), 16'h0003);
        chk("rst_cpu_dout", 16'(cpu_dout), 16'h0000);
        chk("rst_cpu_hit", 16'(cpu_hit), 16'h0000);
    endtask

    initial begin
        int r, a;
        n_reset  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_rd   = 1'b0;
        cpu_addr = 8'h00;
        cpu_din  = 8'h00;
        tx_ready = '0;
        rx_valid = '0;
        rx_data  = '0;
        @(posedge clk);
        #1;
        do_reset();
        rd(BASE + 8'd1);
        chk("st0_reset", 16'(cpu_dout), 16'h0006);
        rd(BASE + 8'd3);
        chk("st1_reset", 16'(cpu_dout), 16'h0006);

        // Two bytes stream straight through TX0
        tx_ready = 2'b01;
        wr(BASE, 8'h5A);
        chk("tx0_first", 16'(tx_data[7:0]), 16'h005A);
        wr(BASE, 8'hA5);
        chk("tx0_second", 16'(tx_data[7:0]), 16'h00A5);
        idle();
        chk("tx_drained", 16'(tx_valid), 16'h0000);
        tx_ready = 2'b00;

        // One byte parked in RX0 so its empty flag stays clear below
        rx_valid = 2'b01;
        rx_data  = 16'h00AB;
        idle();
        rx_valid = 2'b00;

        // Overflow of TX0, then W1C of tx_ovf, then drain
        for (int i = 0; i < 5; i++) wr(BASE, 8'(8'h10 + i));
        rd(BASE + 8'd1);
        chk("st0_ovf", 16'(cpu_dout), 16'h0011);
        wr(BASE + 8'd1, 8'h10);
        rd(BASE + 8'd1);
        chk("st0_ovf_clr", 16'(cpu_dout), 16'h0001);
        tx_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            chk("drain_ovf", 16'(tx_data[7:0]), 16'(8'h10 + i));
            idle();
        end
        chk("drain_ovf_end", 16'(tx_valid), 16'h0000);
        tx_ready = 2'b00;

        // RX1 read, then underflow
        rx_valid = 2'b10;
        rx_data  = 16'h3300;
        idle();
        rx_valid = 2'b00;
        rd(BASE + 8'd2);
        chk("rx1_data", 16'(cpu_dout), 16'h0033);
        chk("rx1_hit", 16'(cpu_hit), 16'h0001);
        rd(BASE + 8'd2);
        chk("rx1_unf_data", 16'(cpu_dout), 16'h0000);
        chk("rx1_unf_hit", 16'(cpu_hit), 16'h0001);
        rd(BASE + 8'd3);
        chk("st1_unf", 16'(cpu_dout), 16'h0026);
        wr(BASE + 8'd3, 8'h20);

        // Push into a full TX0 while the host pops it
        for (int i = 1; i <= 4; i++) wr(BASE, 8'(i));
        tx_ready = 2'b01;
        wr(BASE, 8'h77);
        tx_ready = 2'b00;
        rd(BASE + 8'd1);
        chk("st0_full_no_ovf", 16'(cpu_dout), 16'h0001);
        tx_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 3) ? 8'h77 : 8'(i + 2);
            chk("drain_full", 16'(tx_data[7:0]), 16'(exp_b));
            idle();
        end
        tx_ready = 2'b00;

        // Mid-operation reset discards buffered data and flags
        rd(BASE);
        chk("rx0_parked", 16'(cpu_dout), 16'h00AB);
        rd(BASE);
        for (int i = 0; i < 3; i++) begin
            rx_valid = 2'b10;
            rx_data  = 16'(($urandom & 32'hFF) << 8);
            wr(BASE, 8'($urandom));
        end
        rx_valid = 2'b00;
        do_reset();
        rd(BASE + 8'd1);
        chk("st0_after_rst", 16'(cpu_dout), 16'h0006);
        rd(BASE + 8'd3);
        chk("st1_after_rst", 16'(cpu_dout), 16'h0006);

        // Random traffic on both sides, including collisions and stray addresses
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            a = int'($urandom_range(0, 9));
            cpu_wr = (r <= 2) || (r == 6);
            cpu_rd = (r >= 3) && (r <= 6);
            case (a)
                0:       cpu_addr = 8'hEF;
                1:       cpu_addr = 8'hF4;
                2:       cpu_addr = 8'($urandom);
                default: cpu_addr = BASE + 8'($urandom_range(0, 3));
            endcase
            cpu_din  = 8'($urandom);
            tx_ready = 2'($urandom);
            rx_valid = 2'($urandom);
            rx_data  = 16'($urandom);
            step();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
